cpu_stage_controller: RTL and testbench
=======================================

# cpu_stage_controller

Multi-cycle sequencer for the non-pipelined RV32I core. Walks each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK. Emits one-cycle latch enables for the IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus PC and register-file write strobes. Handshakes with instruction and data memory, with timeout detection.

## Interface
- `TIMEOUT`, 15: max cycles a memory request waits for ack; 0 disables the timeout.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  leaves IDLE; ignored in every other state.
- `opcode`  in  7  IF_ID_IR[6:0]; sampled in DECODE.
- `imem_ack`  in  1  instruction fetch complete.
- `dmem_ack`  in  1  data access complete.
- `imem_req`  out  1  level; high throughout FETCH.
- `dmem_req`  out  1  level; high throughout MEMORY.
- `dmem_we`  out  1  high with dmem_req for STORE.
- `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en`  out  1 each  pipeline-register load pulses.
- `pc_en`  out  1  PC update pulse, one per retired instruction.
- `rf_we`  out  1  register-file write pulse.
- `halted`  out  1  sticky, set on SYSTEM opcode.
- `err_code`  out  2  sticky error code: 00 none, 01 imem timeout, 10 dmem timeout, 11 illegal opcode.
- `state`  out  3  current state encoding, for debug.

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6, ERROR=7.
- **IDLE:** go to FETCH when start=1.
- **FETCH:** imem_req=1. On imem_ack: if_id_en=1 in the same cycle, then go to DECODE.
- **DECODE:** latch opcode into opcode_q.
  - SYSTEM (1110011): go to HALT.
  - Opcode not in {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM}: go to ERROR with code 11.
  - Otherwise: id_ex_en=1, then go to EXECUTE.
- **EXECUTE:** ex_mem_en=1, then branch on opcode_q:
  - LOAD or STORE: go to MEMORY.
  - LUI, AUIPC, JAL, JALR, OP-IMM, OP: go to WRITEBACK.
  - BRANCH or MISC-MEM: pc_en=1, then go to FETCH.
- **MEMORY:** dmem_req=1; dmem_we=1 when opcode_q is STORE. On dmem_ack:
  - LOAD: mem_wb_en=1, then go to WRITEBACK.
  - STORE: pc_en=1, then go to FETCH.
- **WRITEBACK:** rf_we=1 and pc_en=1 for one cycle, then go to FETCH.
- **HALT:** halted=1. **ERROR:** err_code held. Both states are terminal until rst_n.
- **Timeout counter:**
  - Cleared on entry to FETCH or MEMORY.
  - Increments each cycle the request is high without ack.
  - When the count equals TIMEOUT with no ack, go to ERROR with code 01 (FETCH) or 10 (MEMORY).
  - An ack in the timeout cycle wins; no error.
- Acks arriving outside FETCH/MEMORY are ignored.
- All strobes are registered-state decodes and never glitch across states.

## Timing
- Reset (async assert, sync deassert): state=IDLE. All outputs 0, err_code=00, counters 0.
- Reset mid-operation drops requests immediately; no pc_en or rf_we is issued.
- Cycles per instruction with zero-wait ack (ack in the first request cycle):
  - OP/OP-IMM/LUI/AUIPC/JAL/JALR: 4.
  - LOAD: 5.
  - STORE: 4.
  - BRANCH/MISC-MEM: 3.
- Each wait cycle adds 1.
- pc_en is asserted in exactly the last cycle of each instruction.
- The first FETCH begins the cycle after start is sampled.

## Configuration
- `CTRL_PERF_CNT_EN` defined:
  - Adds `cycle_cnt` (out, 32): counts every cycle outside IDLE/HALT/ERROR.
  - Adds `instret` (out, 32): counts pc_en pulses.
  - Both counters wrap modulo 2^32 and reset to 0.
- Undefined: these ports and their logic are absent. Sequencing is identical either way.

## Structure
- Package `rv32i_ctrl_pkg` holds:
  - State enum/localparams.
  - The 7-bit opcode constants.
  - err_code values.
- Sub-module `ctrl_timeout`: counter with clear, enable and `expired` flag, parameterised by TIMEOUT. It is instantiated once and shared, since only one request is active at a time.

## Test plan
- ADD opcode 0110011, acks in the first cycle → if_id_en@1, id_ex_en@2, ex_mem_en@3, rf_we+pc_en@4, back to FETCH.
- LOAD 0000011, dmem_ack after 3 wait cycles → mem_wb_en in the ack cycle; rf_we one cycle later; 8 cycles total.
- STORE 0100011 → dmem_we=1 with dmem_req; pc_en on ack; rf_we never asserts.
- TIMEOUT=4, imem_ack never asserted → ERROR after 4 request cycles, err_code=01. Repeat with ack exactly in cycle 4 → no error.
- Opcode 1111111 → ERROR, code 11; opcode 1110011 → HALT with halted=1, and start is ignored afterwards.
- rst_n pulsed low in the middle of MEMORY → dmem_req drops immediately, state=IDLE, and (with CTRL_PERF_CNT_EN) instret=0.

Source files
------------

// File: rtl/rv32i_ctrl_pkg.sv
// rv32i_ctrl_pkg: state encoding, RV32I opcode constants and error codes for the stage controller
package rv32i_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_HALT, S_ERROR
  } state_t;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_IMEM    = 2'b01;
  localparam logic [1:0] ERR_DMEM    = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;
  function automatic logic is_legal(input logic [6:0] op);
    return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
                      OP_STORE, OP_IMM, OP_OP, OP_MISC_MEM, OP_SYSTEM};
  endfunction
endpackage

// File: rtl/ctrl_timeout.sv
// ctrl_timeout: shared wait counter; expired flags the TIMEOUT-th consecutive un-acked request cycle (0 disables)
module ctrl_timeout #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  // cnt holds the wait cycles already elapsed, so the current cycle is number cnt+1
  assign expired = (TIMEOUT != 0) && en && (cnt == LAST);
endmodule

// File: rtl/cpu_stage_controller.sv
// cpu_stage_controller: multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for the RV32I core.
// Define CTRL_PERF_CNT_EN to add the cycle_cnt and instret performance counters.
module cpu_stage_controller
  import rv32i_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        pc_en,
  output logic        rf_we,
  output logic        halted,
  output logic [1:0]  err_code,
`ifdef CTRL_PERF_CNT_EN
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret,
`endif
  output logic [2:0]  state
);
  state_t cur, nxt;
  logic [6:0] opcode_q;
  logic [1:0] err_q, err_d;
  logic wait_cyc, expired, is_store, is_mem, is_short;
  assign is_store = opcode_q == OP_STORE;
  assign is_mem   = opcode_q == OP_LOAD || is_store;
  assign is_short = opcode_q == OP_BRANCH || opcode_q == OP_MISC_MEM;
  assign wait_cyc = (cur == S_FETCH && !imem_ack) || (cur == S_MEMORY && !dmem_ack);
  // every exit from FETCH/MEMORY is an ack or an expiry, so clearing on non-wait cycles also clears on entry
  ctrl_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk(clk), .rst_n(rst_n), .clr(!wait_cyc), .en(wait_cyc), .expired(expired)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cur      <= S_IDLE;
      opcode_q <= '0;
      err_q    <= ERR_NONE;
    end else begin
      cur   <= nxt;
      err_q <= err_d;
      if (cur == S_DECODE) opcode_q <= opcode;
    end
  always_comb begin
    nxt       = cur;
    err_d     = err_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    if_id_en  = 1'b0;
    id_ex_en  = 1'b0;
    ex_mem_en = 1'b0;
    mem_wb_en = 1'b0;
    pc_en     = 1'b0;
    rf_we     = 1'b0;
    case (cur)
      S_IDLE: nxt = start ? S_FETCH : S_IDLE;
      S_FETCH: begin
        imem_req = 1'b1;
        if_id_en = imem_ack;
        nxt      = imem_ack ? S_DECODE : expired ? S_ERROR : S_FETCH;
        err_d    = expired ? ERR_IMEM : err_q;
      end
      S_DECODE: begin
        id_ex_en = is_legal(opcode) && opcode != OP_SYSTEM;
        nxt      = opcode == OP_SYSTEM ? S_HALT : is_legal(opcode) ? S_EXECUTE : S_ERROR;
        err_d    = is_legal(opcode) ? err_q : ERR_ILLEGAL;
      end
      S_EXECUTE: begin
        ex_mem_en = 1'b1;
        pc_en     = is_short;
        nxt       = is_mem ? S_MEMORY : is_short ? S_FETCH : S_WRITEBACK;
      end
      S_MEMORY: begin
        dmem_req  = 1'b1;
        dmem_we   = is_store;
        mem_wb_en = dmem_ack && !is_store;
        pc_en     = dmem_ack && is_store;
        nxt       = dmem_ack ? (is_store ? S_FETCH : S_WRITEBACK) : expired ? S_ERROR : S_MEMORY;
        err_d     = expired ? ERR_DMEM : err_q;
      end
      S_WRITEBACK: begin
        rf_we = 1'b1;
        pc_en = 1'b1;
        nxt   = S_FETCH;
      end
      default: nxt = cur;
    endcase
  end
  assign halted   = cur == S_HALT;
  assign err_code = err_q;
  assign state    = cur;
`ifdef CTRL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cycle_cnt <= '0;
      instret   <= '0;
    end else begin
      if (!(cur inside {S_IDLE, S_HALT, S_ERROR})) cycle_cnt <= cycle_cnt + 32'd1;
      if (pc_en) instret <= instret + 32'd1;
    end
`endif
endmodule

// File: tb/tb_cpu_stage_controller.sv
// tb_cpu_stage_controller: directed per-cycle vectors pushed to a scoreboard queue, checked by a negedge monitor
module tb_cpu_stage_controller;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
  logic [6:0] opcode = '0;
  logic imem_req, dmem_req, dmem_we, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, pc_en, rf_we, halted;
  logic [1:0] err_code;
  logic [2:0] state;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret;
`endif
  cpu_stage_controller #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .pc_en(pc_en), .rf_we(rf_we), .halted(halted),
    .err_code(err_code),
`ifdef CTRL_PERF_CNT_EN
    .cycle_cnt(cycle_cnt), .instret(instret),
`endif
    .state(state)
  );
  always #5 clk = ~clk;
  localparam logic [9:0] IR = 10'h200, DR = 10'h100, WE = 10'h080, IF = 10'h040, IDX = 10'h020;
  localparam logic [9:0] EXM = 10'h010, MW = 10'h008, PC = 10'h004, RF = 10'h002, HL = 10'h001, NO = 10'h000;
  localparam logic [6:0] ADD = 7'b0110011, LD = 7'b0000011, ST = 7'b0100011, BR = 7'b1100011;
  localparam logic [6:0] FEN = 7'b0001111, SYS = 7'b1110011, BAD = 7'b1111111, X = 7'b0000000;
  typedef struct packed { logic [2:0] st; logic [9:0] fl; logic [1:0] ec; } exp_t;
  exp_t q[$];
  int checks = 0, passed = 0, cyc = 0;
  task automatic step(input logic r, s, ia, da, input logic [6:0] op,
                      input logic [2:0] st, input logic [9:0] fl, input logic [1:0] ec);
    @(posedge clk);
    #1;
    rst_n = r; start = s; imem_ack = ia; dmem_ack = da; opcode = op;
    q.push_back('{st, fl, ec});
  endtask
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      exp_t a;
      e = q.pop_front();
      a = '{state, {imem_req, dmem_req, dmem_we, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, pc_en, rf_we, halted}, err_code};
      checks++;
      if (a === e) passed++;
      else $display("FAIL cycle %0d: got state=%0d strobes=%b err=%b, want state=%0d strobes=%b err=%b",
                    cyc, a.st, a.fl, a.ec, e.st, e.fl, e.ec);
`ifdef CTRL_PERF_CNT_EN
      if (!rst_n) begin
        checks++;
        if (instret === 32'd0 && cycle_cnt === 32'd0) passed++;
        else $display("FAIL perf_reset cycle %0d: got instret=%0d cycle_cnt=%0d, want 0/0", cyc, instret, cycle_cnt);
      end
`endif
      cyc++;
    end
  end
  initial begin
    step(0, 0, 0, 0, X, 0, NO, 0);
    step(0, 1, 1, 1, X, 0, NO, 0);
    step(1, 1, 0, 0, X, 0, NO, 0);
    // ADD, zero-wait
    step(1, 0, 1, 0, X, 1, IR | IF, 0);
    step(1, 0, 1, 1, ADD, 2, IDX, 0);
    step(1, 0, 0, 1, X, 3, EXM, 0);
    step(1, 0, 0, 0, X, 5, RF | PC, 0);
    // LOAD with 3 dmem wait cycles; ack lands in the timeout cycle and wins
    step(1, 0, 1, 0, X, 1, IR | IF, 0);
    step(1, 0, 0, 0, LD, 2, IDX, 0);
    step(1, 0, 0, 0, X, 3, EXM, 0);
    step(1, 0, 0, 0, X, 4, DR, 0);
    step(1, 0, 0, 0, X, 4, DR, 0);
    step(1, 0, 0, 0, X, 4, DR, 0);
    step(1, 0, 0, 1, X, 4, DR | MW, 0);
    step(1, 0, 0, 0, X, 5, RF | PC, 0);
    // STORE with one wait cycle
    step(1, 0, 1, 0, X, 1, IR | IF, 0);
    step(1, 0, 0, 0, ST, 2, IDX, 0);
    step(1, 0, 0, 0, X, 3, EXM, 0);
    step(1, 0, 0, 0, X, 4, DR | WE, 0);
    step(1, 0, 0, 1, X, 4, DR | WE | PC, 0);
    // BRANCH
    step(1, 0, 1, 0, X, 1, IR | IF, 0);
    step(1, 0, 0, 0, BR, 2, IDX, 0);
    step(1, 0, 0, 0, X, 3, EXM | PC, 0);
    // FENCE fetched with imem_ack exactly in the 4th request cycle
    step(1, 0, 0, 0, X, 1, IR, 0);
    step(1, 0, 0, 0, X, 1, IR, 0);
    step(1, 0, 0, 0, X, 1, IR, 0);
    step(1, 0, 1, 0, X, 1, IR | IF, 0);
    step(1, 0, 0, 0, FEN, 2, IDX, 0);
    step(1, 0, 0, 0, X, 3, EXM | PC, 0);
    // imem timeout after 4 request cycles
    step(1, 0, 0, 0, X, 1, IR, 0);
    step(1, 0, 0, 0, X, 1, IR, 0);
    step(1, 0, 0, 0, X, 1, IR, 0);
    step(1, 0, 0, 0, X, 1, IR, 0);
    step(1, 1, 1, 1, X, 7, NO, 1);
    step(1, 0, 0, 0, X, 7, NO, 1);
    // illegal opcode
    step(0, 0, 0, 0, X, 0, NO, 0);
    step(1, 1, 0, 0, X, 0, NO, 0);
    step(1, 0, 1, 0, X, 1, IR | IF, 0);
    step(1, 0, 0, 0, BAD, 2, NO, 0);
    step(1, 0, 0, 0, X, 7, NO, 3);
    // SYSTEM halts; start is ignored afterwards
    step(0, 0, 0, 0, X, 0, NO, 0);
    step(1, 1, 0, 0, X, 0, NO, 0);
    step(1, 0, 1, 0, X, 1, IR | IF, 0);
    step(1, 0, 0, 0, SYS, 2, NO, 0);
    step(1, 1, 1, 1, X, 6, HL, 0);
    step(1, 1, 0, 0, X, 6, HL, 0);
    // dmem timeout on a LOAD
    step(0, 0, 0, 0, X, 0, NO, 0);
    step(1, 1, 0, 0, X, 0, NO, 0);
    step(1, 0, 1, 0, X, 1, IR | IF, 0);
    step(1, 0, 0, 0, LD, 2, IDX, 0);
    step(1, 0, 0, 0, X, 3, EXM, 0);
    step(1, 0, 0, 0, X, 4, DR, 0);
    step(1, 0, 0, 0, X, 4, DR, 0);
    step(1, 0, 0, 0, X, 4, DR, 0);
    step(1, 0, 0, 0, X, 4, DR, 0);
    step(1, 0, 0, 0, X, 7, NO, 2);
    // reset in the middle of a STORE's MEMORY state, with ack arriving at the same time
    step(0, 0, 0, 0, X, 0, NO, 0);
    step(1, 1, 0, 0, X, 0, NO, 0);
    step(1, 0, 1, 0, X, 1, IR | IF, 0);
    step(1, 0, 0, 0, ST, 2, IDX, 0);
    step(1, 0, 0, 0, X, 3, EXM, 0);
    step(1, 0, 0, 0, X, 4, DR | WE, 0);
    step(0, 0, 0, 1, X, 0, NO, 0);
    step(1, 0, 0, 1, X, 0, NO, 0);
    step(1, 0, 1, 1, X, 0, NO, 0);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
